gray_fifo_ctrl: RTL
===================

// Module: gray_fifo_ctrl
// PURPOSE
//  Single-clock FIFO pointer controller that sequences a write and a read gray pointer.
//  Accepts write/read requests, gates the pointer/RAM enables and keeps full/empty/level.
//  Exports gray-coded pointers for downstream clock-domain-crossing logic.
//  Sits between producer/consumer handshakes and a dual-port RAM of 2**AW words.
// PARAMETERS
//  AW        4   address width; depth = 2**AW, pointers are AW+1 bits
//  AFULL_TH  12  almost_full asserts when level >= AFULL_TH (1..2**AW)
// PORTS
//  clk          in   1     clock, all logic on rising edge
//  rst_n        in   1     reset, asynchronous, active-high
//  wr_req       in   1     producer requests a write this cycle
//  rd_req       in   1     consumer requests a read this cycle
//  wr_en        out  1     write accepted (combinational): wr_req & ~full
//  rd_en        out  1     read accepted (combinational): rd_req & ~empty
//  wr_addr      out  AW    RAM write address (low AW bits of binary write ptr)
//  rd_addr      out  AW    RAM read address (low AW bits of binary read ptr)
//  wr_ptr_gray  out  AW+1  registered gray-coded write pointer
//  rd_ptr_gray  out  AW+1  registered gray-coded read pointer
//  level        out  AW+1  registered occupancy, 0..2**AW
//  full         out  1     registered, level == 2**AW
//  empty        out  1     registered, level == 0
//  almost_full  out  1     registered, level >= AFULL_TH
//  overflow     out  1     1-cycle pulse, registered: wr_req while full
//  underflow    out  1     1-cycle pulse, registered: rd_req while empty
// BEHAVIOUR
//  - Reset (rst_n=1, async): binary/gray ptrs=0, level=0, empty=1, full=0,
//    almost_full=0, overflow=0, underflow=0. Reset mid-operation discards all contents.
//  - Acceptance evaluated on flags of the current cycle; wr_en/rd_en are combinational.
//  - Accepted write: wr_bin <= wr_bin+1 (mod 2**(AW+1)); same for read with rd_en.
//  - Gray: g = b ^ (b >> 1), registered from the next binary value, so it updates
//    the same edge as the binary ptr; exactly one bit changes per increment.
//  - level <= level + wr_en - rd_en; full/empty/almost_full are computed from the next
//    level and registered, so they are valid one cycle after the edge that accepts.
//  - Cross-check: empty iff wr_ptr_gray==rd_ptr_gray; full iff the top two gray bits
//    differ and the remaining bits are equal.
//  - Simultaneous wr_req & rd_req:
//    - neither full nor empty: both are accepted and level is unchanged.
//    - full: read is accepted, write is rejected (overflow pulses) and level becomes 2**AW-1.
//    - empty: write is accepted, read is rejected (underflow pulses) and level becomes 1.
//  - Rejected requests never move pointers; requesters must retry.
//  - Wrap-around: pointers roll from 2**(AW+1)-1 to 0 without loss; addr wraps every 2**AW.
//  - A request held during reset is ignored; the first acceptance is the first edge after reset release.
// TESTING
//  1. Reset: hold rst_n=1 for 10 cycles, then release -> empty=1, level=0, ptrs=0, no enables.
//  2. Fill: wr_req=1 for 18 cycles, AW=4 -> 16 wr_en pulses; almost_full after the 12th;
//     full after the 16th; 2 overflow pulses; wr_ptr_gray=5'b11000.
//  3. Drain: rd_req=1 for 17 cycles from full -> 16 rd_en; empty=1; 1 underflow;
//     rd_ptr_gray==wr_ptr_gray.
//  4. Gray walk: 64 writes each followed by a read -> every gray ptr step has Hamming
//     distance 1; the ptr wraps twice; wr_addr sequence is 0..15 repeated.
//  5. Simultaneous: at full assert both -> rd_en=1, wr_en=0, overflow=1, level=15;
//     at level 5 assert both for 10 cycles -> level stays 5.
//  6. Mid-op reset: at level 9 assert rst_n=1 asynchronously between edges -> all outputs
//     immediately take their reset values; the next write lands at addr 0.

Source files
------------

// File: rtl/gray_fifo_ctrl.sv
// Single-clock FIFO pointer controller: binary/gray write and read pointers,
// occupancy level, registered status flags and overflow/underflow pulses.
module gray_fifo_ctrl #(
  parameter int unsigned AW       = 4,
  parameter int unsigned AFULL_TH = 12
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          wr_req,
  input  logic          rd_req,
  output logic          wr_en,
  output logic          rd_en,
  output logic [AW-1:0] wr_addr,
  output logic [AW-1:0] rd_addr,
  output logic [AW:0]   wr_ptr_gray,
  output logic [AW:0]   rd_ptr_gray,
  output logic [AW:0]   level,
  output logic          full,
  output logic          empty,
  output logic          almost_full,
  output logic          overflow,
  output logic          underflow
);

  localparam int unsigned PW = AW + 1;
  localparam logic [PW-1:0] Depth = {1'b1, {AW{1'b0}}};
  localparam logic [PW-1:0] AfullLevel = PW'(AFULL_TH);

  logic [PW-1:0] wr_bin_q, wr_bin_d;
  logic [PW-1:0] rd_bin_q, rd_bin_d;
  logic [PW-1:0] wr_gray_q, wr_gray_d;
  logic [PW-1:0] rd_gray_q, rd_gray_d;
  logic [PW-1:0] level_q, level_d;
  logic          full_q, full_d;
  logic          empty_q, empty_d;
  logic          afull_q, afull_d;
  logic          ovf_q, ovf_d;
  logic          udf_q, udf_d;

  // Requests are blocked while reset is held so nothing is accepted until release.
  always_comb begin
    wr_en = wr_req & ~full_q & ~rst_n;
    rd_en = rd_req & ~empty_q & ~rst_n;
  end

  always_comb begin
    wr_bin_d  = wr_bin_q + PW'(wr_en);
    rd_bin_d  = rd_bin_q + PW'(rd_en);
    wr_gray_d = wr_bin_d ^ (wr_bin_d >> 1);
    rd_gray_d = rd_bin_d ^ (rd_bin_d >> 1);
    level_d   = level_q + PW'(wr_en) - PW'(rd_en);
    // Flags come from the next level so they line up with the registered level.
    full_d    = (level_d == Depth);
    empty_d   = (level_d == '0);
    afull_d   = (level_d >= AfullLevel);
    ovf_d     = wr_req & full_q;
    udf_d     = rd_req & empty_q;
  end

  always_ff @(posedge clk or posedge rst_n) begin
    if (rst_n) begin
      wr_bin_q  <= '0;
      rd_bin_q  <= '0;
      wr_gray_q <= '0;
      rd_gray_q <= '0;
      level_q   <= '0;
      full_q    <= 1'b0;
      empty_q   <= 1'b1;
      afull_q   <= 1'b0;
      ovf_q     <= 1'b0;
      udf_q     <= 1'b0;
    end else begin
      wr_bin_q  <= wr_bin_d;
      rd_bin_q  <= rd_bin_d;
      wr_gray_q <= wr_gray_d;
      rd_gray_q <= rd_gray_d;
      level_q   <= level_d;
      full_q    <= full_d;
      empty_q   <= empty_d;
      afull_q   <= afull_d;
      ovf_q     <= ovf_d;
      udf_q     <= udf_d;
    end
  end

  always_comb begin
    wr_addr     = wr_bin_q[AW-1:0];
    rd_addr     = rd_bin_q[AW-1:0];
    wr_ptr_gray = wr_gray_q;
    rd_ptr_gray = rd_gray_q;
    level       = level_q;
    full        = full_q;
    empty       = empty_q;
    almost_full = afull_q;
    overflow    = ovf_q;
    underflow   = udf_q;
  end

endmodule
